seg_bus_reader: RTL and testbench
=================================

Name: seg_bus_reader

Overview:
- Receive-side controller for the shared 7-bit tri-state segment bus that the team's enable-gated bus drivers feed.
- Sequences one-hot enables across NUM_SRC drivers, one at a time, and lets the bus settle.
- Samples the resolved bus value and decodes the 7-segment glyph back to a 4-bit hex value.
- Hands each decoded value to the consumer over a valid/ready handshake, so the CPU debug path can read back what each display source is driving.

Parameters:
- NUM_SRC, 4, number of tri-state drivers on the bus; legal range 2..16.
- SETTLE_CYC, 2, cycles an enable is held before sampling; must be >=1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  pulse: begin one scan of all sources; ignored while busy=1
- bus_in  in  7  resolved shared bus; bit0=a ... bit6=g, active-high segments
- src_en  out  NUM_SRC  one-hot driver enables; all-zero when the bus is released
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- rd_valid  out  1  decoded result available
- rd_ready  in  1  consumer accepts the result
- rd_src  out  $clog2(NUM_SRC)  index of the source the result came from
- rd_hex  out  4  decoded hex digit
- rd_err  out  1  sampled pattern is not a legal glyph

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs go to 0 and the FSM goes to IDLE. This applies mid-scan too: the current scan is aborted, src_en is released, and no result is emitted.
- FSM states and transitions:
  - IDLE: start=1 -> DRIVE with src index i=0.
  - DRIVE: src_en[i]=1; settle counter counts SETTLE_CYC cycles, then -> SAMPLE.
  - SAMPLE: src_en[i] stays 1 for this one cycle; bus_in is registered and decoded into rd_hex, rd_err and rd_src=i; -> HOLD.
  - HOLD: src_en=0 and rd_valid=1. On rd_valid&&rd_ready: if i==NUM_SRC-1 -> IDLE, otherwise i+1 -> DRIVE.
- Latency: if start is sampled at edge 0, src_en is visible after edge 1 and rd_valid after edge SETTLE_CYC+2.
- Handshake:
  - rd_src, rd_hex and rd_err stay stable while rd_valid=1 and rd_ready=0.
  - rd_valid drops on the edge after the handshake completes.
  - rd_ready=1 held high still costs one HOLD cycle per source.
- Break-before-make: HOLD always occupies at least one cycle with src_en=0, so enables never overlap or switch directly from one source to the next.
- busy=0 in IDLE; start pulses during busy are dropped, not queued.
- Decode table (bus_in hex -> digit): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
- Any other pattern, including 00 (no driver or blank), gives rd_hex=0, rd_err=1.
- Decode works on 0/1 values only; a bus left at Z/X in simulation is a test failure, not a defined case.

Optional Feature:
- Macro: SEG_BUS_ACTIVE_LOW_EN.
- Defined: bus_in is inverted before decode (common-anode bus). An all-ones bus (7F) then decodes as blank -> rd_err=1.
- Undefined: active-high decoding as specified above.
- Port list is identical either way.

Decomposition:
- Shared package seg_bus_pkg holds:
  - the FSM state enum (IDLE, DRIVE, SAMPLE, HOLD);
  - the 16-entry glyph constants (SEG_GLYPH_0..SEG_GLYPH_F);
  - a localparam for the segment width (7).
- One natural sub-module, seg7_glyph_decode: combinational, 7-bit pattern -> {err, hex[3:0]}, shared with any future display self-test.
- The FSM, settle counter and output registers stay in seg_bus_reader.

Test Plan:
- Reset, then start; bus model drives 06 on src0, 5B on src1, 4F on src2, 66 on src3; rd_ready=1 -> four results, src 0..3, hex 1,2,3,4, rd_err=0; busy falls after the fourth handshake.
- Latency check, SETTLE_CYC=2: start at edge 0 -> src_en=0001 after edge 1; rd_valid after edge 4; src_en never has two bits set, and is all-zero for at least one cycle between sources.
- Backpressure: hold rd_ready=0 for 5 cycles on src1 (pattern 7C) -> rd_valid, rd_src=1 and rd_hex=B held stable; src_en=0 throughout; scan resumes after rd_ready=1.
- Illegal patterns: src2 drives 00, src3 drives 55 -> rd_err=1 and rd_hex=0 for both.
- Reset mid-scan: assert rst_n=0 in DRIVE for src1 -> next edge all outputs 0 and IDLE; a start issued during busy before the reset produces no extra scan.
- With SEG_BUS_ACTIVE_LOW_EN: bus 40 -> hex 0, rd_err=0; bus 7F -> rd_err=1.

Source files
------------

// File: rtl/seg_bus_pkg.sv
// Shared definitions for the segment-bus read-back path: bus width,
// scan FSM states and the canonical active-high 7-segment glyphs
// (bit0 = a ... bit6 = g).
package seg_bus_pkg;

    localparam int SEG_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } seg_state_e;

    localparam logic [SEG_W-1:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph decoder: active-high pattern -> hex digit.
// Anything that is not one of the 16 hex glyphs (blank included) reports
// err=1 with hex forced to 0.
module seg7_glyph_decode
    import seg_bus_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             err,
    output logic [3:0]       hex
);

    // Table lookup of the glyph; unknown patterns fall into the error arm.
    always_comb begin
        err = 1'b0;
        hex = 4'h0;
        case (pattern)
            SEG_GLYPH_0: hex = 4'h0;
            SEG_GLYPH_1: hex = 4'h1;
            SEG_GLYPH_2: hex = 4'h2;
            SEG_GLYPH_3: hex = 4'h3;
            SEG_GLYPH_4: hex = 4'h4;
            SEG_GLYPH_5: hex = 4'h5;
            SEG_GLYPH_6: hex = 4'h6;
            SEG_GLYPH_7: hex = 4'h7;
            SEG_GLYPH_8: hex = 4'h8;
            SEG_GLYPH_9: hex = 4'h9;
            SEG_GLYPH_A: hex = 4'hA;
            SEG_GLYPH_B: hex = 4'hB;
            SEG_GLYPH_C: hex = 4'hC;
            SEG_GLYPH_D: hex = 4'hD;
            SEG_GLYPH_E: hex = 4'hE;
            SEG_GLYPH_F: hex = 4'hF;
            default: begin
                err = 1'b1;
                hex = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg_bus_reader.sv
// Receive-side scanner for the shared tri-state segment bus. Enables one
// driver at a time, lets the bus settle, samples and decodes the glyph and
// hands {src, hex, err} to the consumer over valid/ready.
// Build option SEG_BUS_ACTIVE_LOW_EN: bus is common-anode, inverted before
// decode. Port list is the same in both builds.
module seg_bus_reader
    import seg_bus_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SEG_W-1:0]           bus_in,
    output logic [NUM_SRC-1:0]         src_en,
    output logic                       busy,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(NUM_SRC)-1:0] rd_src,
    output logic [3:0]                 rd_hex,
    output logic                       rd_err
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYC);
    localparam logic [NUM_SRC-1:0] EN_ONE   = NUM_SRC'(1);

    seg_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] src_en_q, src_en_d;
    logic               busy_q, busy_d;
    logic               rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]   rd_src_q, rd_src_d;
    logic [3:0]         rd_hex_q, rd_hex_d;
    logic               rd_err_q, rd_err_d;

    logic [SEG_W-1:0]   seg_pat_s;
    logic               dec_err_s;
    logic [3:0]         dec_hex_s;

`ifdef SEG_BUS_ACTIVE_LOW_EN
    assign seg_pat_s = ~bus_in;
`else
    assign seg_pat_s = bus_in;
`endif

    seg7_glyph_decode u_decode (
        .pattern (seg_pat_s),
        .err     (dec_err_s),
        .hex     (dec_hex_s)
    );

    // Next-state logic: scan sequencing, settle counting, source index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = {IDX_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                // First DRIVE cycle raises the enable; the remaining
                // SETTLE_CYC cycles are the settle window.
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (rd_valid_q && rd_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRIVE;
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output register inputs: enables, status flags and the captured result.
    always_comb begin
        src_en_d   = {NUM_SRC{1'b0}};
        busy_d     = (state_d != IDLE);
        rd_valid_d = (state_d == HOLD);
        rd_src_d   = rd_src_q;
        rd_hex_d   = rd_hex_q;
        rd_err_d   = rd_err_q;
        // Enable stays low on the DRIVE entry cycle, so HOLD -> DRIVE always
        // leaves the bus released for a while between sources.
        if ((state_d == SAMPLE) || ((state_q == DRIVE) && (state_d == DRIVE))) begin
            src_en_d = EN_ONE << idx_d;
        end else begin
            src_en_d = {NUM_SRC{1'b0}};
        end
        if (state_q == SAMPLE) begin
            rd_src_d = idx_q;
            rd_hex_d = dec_hex_s;
            rd_err_d = dec_err_s;
        end else begin
            rd_src_d = rd_src_q;
            rd_hex_d = rd_hex_q;
            rd_err_d = rd_err_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= {IDX_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            src_en_q   <= {NUM_SRC{1'b0}};
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_src_q   <= {IDX_W{1'b0}};
            rd_hex_q   <= 4'h0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            src_en_q   <= src_en_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_src_q   <= rd_src_d;
            rd_hex_q   <= rd_hex_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign src_en   = src_en_q;
    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_src   = rd_src_q;
    assign rd_hex   = rd_hex_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_seg_bus_reader.sv
// Self-checking bench for seg_bus_reader: a bus model drives per-source
// patterns, and results are compared with a glyph-table reference decode.
module tb_seg_bus_reader;

    localparam int NUM_SRC    = 4;
    localparam int SETTLE_CYC = 2;
    localparam int IDX_W      = $clog2(NUM_SRC);

    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [6:0]         bus_in;
    logic [NUM_SRC-1:0] src_en;
    logic               busy;
    logic               rd_valid;
    logic               rd_ready;
    logic [IDX_W-1:0]   rd_src;
    logic [3:0]         rd_hex;
    logic               rd_err;

    int checks   = 0;
    int failures = 0;

    logic [6:0]         src_pat [NUM_SRC];
    logic [4:0]         got_res [NUM_SRC];
    logic [IDX_W-1:0]   got_src [NUM_SRC];
    logic [NUM_SRC-1:0] prev_en = '0;

    seg_bus_reader #(.NUM_SRC(NUM_SRC), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus_in   (bus_in),
        .src_en   (src_en),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_src   (rd_src),
        .rd_hex   (rd_hex),
        .rd_err   (rd_err)
    );

    always #5 clk = ~clk;

    // Shared bus: the enabled driver's pattern, pulled to 00 when released.
    always_comb begin
        bus_in = 7'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_en[i]) bus_in = src_pat[i];
        end
    end

    // Enables must be one-hot-or-zero and never hop directly between sources.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones(src_en) > 1) begin
                failures++;
                $display("FAIL onehot got=%b required at most one bit set", src_en);
            end
            checks++;
            if (prev_en != '0 && src_en != '0 && src_en != prev_en) begin
                failures++;
                $display("FAIL break_before_make got=%b after %b required a released cycle", src_en, prev_en);
            end
        end
        prev_en <= src_en;
    end

    // Logical glyph as it appears on the physical bus for this build.
    function automatic logic [6:0] phys(input logic [6:0] glyph);
`ifdef SEG_BUS_ACTIVE_LOW_EN
        return ~glyph;
`else
        return glyph;
`endif
    endfunction

    // Reference decode: {err, hex} by searching the glyph table.
    function automatic logic [4:0] ref_decode(input logic [6:0] raw);
        logic [6:0] v;
`ifdef SEG_BUS_ACTIVE_LOW_EN
        v = ~raw;
`else
        v = raw;
`endif
        for (int j = 0; j < 16; j++) begin
            if (GLYPH_TBL[j] == v) return {1'b0, 4'(j)};
        end
        return {1'b1, 4'h0};
    endfunction

    function automatic logic [6:0] rand_legal();
        return phys(GLYPH_TBL[$urandom_range(15)]);
    endfunction

    // One full scan; ready_pct = probability of accepting, stall_src is held off stall_cyc cycles.
    task automatic run_scan(input int ready_pct, input int stall_src, input int stall_cyc);
        int idx = 0;
        bit got = 1'b0;
        int stall_left = stall_cyc;
        logic [IDX_W+4:0] saved = '0;
        logic [4:0] exp_res;
        start = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL scan_busy got=%b required 1", busy);
        end
        for (int budget = 0; budget < 500 && idx < NUM_SRC; budget++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                checks++;
                if (src_en !== '0) begin
                    failures++;
                    $display("FAIL hold_released got=%b required 0", src_en);
                end
                if (!got) begin
                    exp_res = ref_decode(src_pat[idx]);
                    checks++;
                    if ({rd_src, rd_err, rd_hex} !== {IDX_W'(idx), exp_res}) begin
                        failures++;
                        $display("FAIL result src=%0d got=%0d/%b/%h required %0d/%b/%h",
                                 idx, rd_src, rd_err, rd_hex, idx, exp_res[4], exp_res[3:0]);
                    end
                    got_src[idx] = rd_src;
                    got_res[idx] = {rd_err, rd_hex};
                    saved = {rd_src, rd_err, rd_hex};
                    got = 1'b1;
                end else begin
                    checks++;
                    if ({rd_src, rd_err, rd_hex} !== saved) begin
                        failures++;
                        $display("FAIL stable got=%h required %h", {rd_src, rd_err, rd_hex}, saved);
                    end
                end
                if (idx == stall_src && stall_left > 0) begin
                    rd_ready = 1'b0;
                    stall_left--;
                end else begin
                    rd_ready = (int'($urandom_range(99)) < ready_pct);
                end
                if (rd_ready) begin
                    idx++;
                    got = 1'b0;
                end
            end else begin
                rd_ready = 1'($urandom_range(1));
            end
        end
        checks++;
        if (idx != NUM_SRC) begin
            failures++;
            $display("FAIL scan_timeout got=%0d results required %0d", idx, NUM_SRC);
        end
        @(negedge clk);
        rd_ready = 1'b0;
        checks++;
        if ({busy, rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL scan_end got busy/valid=%b required 00", {busy, rd_valid});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rd_ready = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_pat[i] = 7'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({src_en, busy, rd_valid, rd_src, rd_hex, rd_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required 0", {src_en, busy, rd_valid, rd_src, rd_hex, rd_err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({src_en, busy, rd_valid} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h required 0", {src_en, busy, rd_valid});
        end
    endtask

    task automatic test_basic();
        src_pat[0] = phys(7'h06);
        src_pat[1] = phys(7'h5B);
        src_pat[2] = phys(7'h4F);
        src_pat[3] = phys(7'h66);
        run_scan(100, -1, 0);
        for (int i = 0; i < NUM_SRC; i++) begin
            checks++;
            if (got_res[i] !== {1'b0, 4'(i + 1)} || got_src[i] !== IDX_W'(i)) begin
                failures++;
                $display("FAIL basic_digit src=%0d got=%0d/%h required %0d/%h",
                         i, got_src[i], got_res[i], i, {1'b0, 4'(i + 1)});
            end
        end
    endtask

    task automatic test_latency();
        bit done = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_pat[i] = rand_legal();
        rd_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, src_en} !== {1'b1, NUM_SRC'(0)}) begin
            failures++;
            $display("FAIL lat_edge0 got=%b required busy=1 src_en=0", {busy, src_en});
        end
        @(negedge clk);
        checks++;
        if (src_en !== NUM_SRC'(1)) begin
            failures++;
            $display("FAIL lat_enable got=%b required %b", src_en, NUM_SRC'(1));
        end
        for (int e = 2; e <= SETTLE_CYC + 1; e++) begin
            @(negedge clk);
            checks++;
            if ({rd_valid, src_en} !== {1'b0, NUM_SRC'(1)}) begin
                failures++;
                $display("FAIL lat_settle edge=%0d got=%b required valid=0 src_en=%b", e, {rd_valid, src_en}, NUM_SRC'(1));
            end
        end
        @(negedge clk);
        checks++;
        if ({rd_valid, src_en, rd_src, rd_err, rd_hex} !== {1'b1, NUM_SRC'(0), IDX_W'(0), ref_decode(src_pat[0])}) begin
            failures++;
            $display("FAIL lat_valid got=%h required %h", {rd_valid, src_en, rd_src, rd_err, rd_hex},
                     {1'b1, NUM_SRC'(0), IDX_W'(0), ref_decode(src_pat[0])});
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        rd_ready = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL lat_drain got busy=%b required 0 within budget", busy);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NUM_SRC; i++) src_pat[i] = rand_legal();
        src_pat[1] = phys(7'h7C);
        run_scan(100, 1, 5);
        checks++;
        if (got_res[1] !== {1'b0, 4'hB}) begin
            failures++;
            $display("FAIL backpressure_digit got=%h required %h", got_res[1], {1'b0, 4'hB});
        end
    endtask

    task automatic test_illegal();
        src_pat[0] = rand_legal();
        src_pat[1] = rand_legal();
        src_pat[2] = phys(7'h00);
        src_pat[3] = phys(7'h55);
        run_scan(70, -1, 0);
        for (int i = 2; i < 4; i++) begin
            checks++;
            if (got_res[i] !== {1'b1, 4'h0}) begin
                failures++;
                $display("FAIL illegal src=%0d got=%h required %h", i, got_res[i], {1'b1, 4'h0});
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if ($urandom_range(3) != 0) src_pat[i] = rand_legal();
                else src_pat[i] = 7'($urandom_range(127));
            end
            run_scan(60, -1, 0);
        end
    endtask

    task automatic test_midscan_reset();
        bit found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_pat[i] = rand_legal();
        rd_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (src_en === NUM_SRC'(2)) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midscan_reach got src_en=%b required %b within budget", src_en, NUM_SRC'(2));
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({src_en, busy, rd_valid, rd_src, rd_hex, rd_err} !== '0) begin
            failures++;
            $display("FAIL midscan_reset got=%h required 0", {src_en, busy, rd_valid, rd_src, rd_hex, rd_err});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({src_en, busy, rd_valid} !== '0) begin
                failures++;
                $display("FAIL midscan_no_rescan got=%b required 0", {src_en, busy, rd_valid});
            end
        end
        rd_ready = 1'b0;
    endtask

`ifdef SEG_BUS_ACTIVE_LOW_EN
    task automatic test_active_low();
        src_pat[0] = 7'h40;
        src_pat[1] = 7'h7F;
        src_pat[2] = phys(7'h3F);
        src_pat[3] = phys(7'h06);
        run_scan(100, -1, 0);
        checks++;
        if (got_res[0] !== {1'b0, 4'h0}) begin
            failures++;
            $display("FAIL active_low_zero got=%h required %h", got_res[0], {1'b0, 4'h0});
        end
        checks++;
        if (got_res[1] !== {1'b1, 4'h0}) begin
            failures++;
            $display("FAIL active_low_blank got=%h required %h", got_res[1], {1'b1, 4'h0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_illegal();
        test_random();
        test_midscan_reset();
`ifdef SEG_BUS_ACTIVE_LOW_EN
        test_active_low();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
